sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one SDRAM controller between NPORTS requesters. Requests are granted
// round-robin while the controller reports ready; the granted port's command
// is latched, presented to the controller with a request/ready handshake, and
// completion is reported back to the port as a one-cycle m_done pulse. A
// watchdog aborts an access (m_done with m_err) if the controller stalls for
// TIMEOUT cycles while busy or while finishing.
//
// Ports
//   CLK          sole clock
//   nRST         asynchronous active-low reset
//   m_req        per-port request
//   m_we         per-port write flag
//   m_addr       per-port address, port i at [32i+31:32i]
//   m_wdata      per-port write data, same packing as m_addr
//   m_ack        one-cycle pulse: port's request has been latched
//   m_done       one-cycle pulse: port's access has completed
//   m_err        qualifies m_done: access timed out
//   m_rdata      read data, valid with m_done of a read
//   sd_request   request to controller
//   sd_ready     ready from controller
//   sd_is_write  access direction to controller
//   sd_address   address to controller
//   sd_data      shared bidirectional data bus to controller
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int unsigned NPORTS  = 4,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NPORTS-1:0]     m_req,
    input  logic [NPORTS-1:0]     m_we,
    input  logic [32*NPORTS-1:0]  m_addr,
    input  logic [32*NPORTS-1:0]  m_wdata,
    output logic [NPORTS-1:0]     m_ack,
    output logic [NPORTS-1:0]     m_done,
    output logic                  m_err,
    output logic [31:0]           m_rdata,
    output logic                  sd_request,
    input  logic                  sd_ready,
    output logic                  sd_is_write,
    output logic [31:0]           sd_address,
    inout  wire  [31:0]           sd_data
);

    localparam int unsigned IdxW = $clog2(NPORTS);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [NPORTS-1:0] ack_q, ack_d;
    logic [NPORTS-1:0] done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       wdog_q, wdog_d;

    logic              wdog_hit;
    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;

    logic [31:0]       addr_arr  [NPORTS];
    logic [31:0]       wdata_arr [NPORTS];

    // Unpack the flat per-port buses so the granted port can be selected by index.
    for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
        assign addr_arr[i]  = m_addr[32*i +: 32];
        assign wdata_arr[i] = m_wdata[32*i +: 32];
    end

    // Round-robin search starting just after the last granted port, with wrap.
    always_comb begin : rr_pick
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cand = 32'(last_q) + 32'd1 + k;
            if (cand >= NPORTS) begin
                cand = cand - NPORTS;
            end
            cand_idx = cand[IdxW-1:0];
            if (!rr_found && m_req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // Fires on the TIMEOUT-th cycle spent in a wait state.
    assign wdog_hit = (wdog_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        wdog_d  = wdog_q;

        unique case (state_q)
            StIdle: begin
                if (sd_ready && rr_found) begin
                    gnt_d         = rr_idx;
                    last_d        = rr_idx;
                    we_d          = m_we[rr_idx];
                    addr_d        = addr_arr[rr_idx];
                    wdata_d       = wdata_arr[rr_idx];
                    ack_d[rr_idx] = 1'b1;
                    state_d       = StIssue;
                end
            end

            StIssue: begin
                // sd_request is high throughout this state, so ready alone accepts.
                if (sd_ready) begin
                    wdog_d  = '0;
                    state_d = StWaitBusy;
                end
            end

            StWaitBusy: begin
                if (!sd_ready) begin
                    wdog_d  = '0;
                    state_d = StWaitDone;
                end else if (wdog_hit) begin
                    done_d[gnt_q] = 1'b1;
                    err_d         = 1'b1;
                    wdog_d        = '0;
                    state_d       = StIdle;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end

            StWaitDone: begin
                if (sd_ready) begin
                    if (!we_q) begin
                        rdata_d = sd_data;
                    end
                    done_d[gnt_q] = 1'b1;
                    wdog_d        = '0;
                    state_d       = StIdle;
                end else if (wdog_hit) begin
                    done_d[gnt_q] = 1'b1;
                    err_d         = 1'b1;
                    wdog_d        = '0;
                    state_d       = StIdle;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            last_q  <= IdxW'(NPORTS - 1);
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    // Every controller-side output comes from registers only.
    assign m_ack       = ack_q;
    assign m_done      = done_q;
    assign m_err       = err_q;
    assign m_rdata     = rdata_q;
    assign sd_request  = (state_q == StIssue);
    assign sd_is_write = we_q;
    assign sd_address  = addr_q;
    assign sd_data     = (state_q == StIssue && we_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed bench for sdram_port_arbiter (NPORTS=4, TIMEOUT=20) with a small
// SDRAM controller model: it accepts a request, holds sd_ready low for
// BUSY_CYC cycles, then raises it and drives read data for one cycle.
// High-Z on sd_data is observed by briefly driving a probe pattern from the
// bench: the pattern reads back intact only if the DUT is not driving.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int unsigned   NP       = 4;
    localparam int unsigned   BUSY_CYC = 8;
    localparam logic [31:0]   PROBE    = 32'hA5A5_5A5A;

    logic            CLK;
    logic            nRST;
    logic [NP-1:0]   m_req;
    logic [NP-1:0]   m_we;
    logic [32*NP-1:0] m_addr;
    logic [32*NP-1:0] m_wdata;
    logic [NP-1:0]   m_ack;
    logic [NP-1:0]   m_done;
    logic            m_err;
    logic [31:0]     m_rdata;
    logic            sd_request;
    logic            sd_ready;
    logic            sd_is_write;
    logic [31:0]     sd_address;
    wire  [31:0]     sd_data;

    int n_vec = 0;
    int n_err = 0;

    sdram_port_arbiter #(
        .NPORTS  (NP),
        .TIMEOUT (16'd20)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_done      (m_done),
        .m_err       (m_err),
        .m_rdata     (m_rdata),
        .sd_request  (sd_request),
        .sd_ready    (sd_ready),
        .sd_is_write (sd_is_write),
        .sd_address  (sd_address),
        .sd_data     (sd_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- controller model ----------------
    logic        mdl_off   = 1'b0;
    logic        mdl_hang  = 1'b0;
    logic        probe_oe  = 1'b0;
    logic        mdl_ready = 1'b1;
    logic        mdl_oe    = 1'b0;
    logic [31:0] mdl_drv   = '0;
    logic        mdl_busy  = 1'b0;
    int unsigned mdl_cnt   = 0;
    logic        acc_we    = 1'b0;
    logic [31:0] acc_addr  = '0;
    logic [31:0] wr_addr   = '0;
    logic [31:0] wr_data   = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFE_F00D;
        if (a == 32'h0)   return 32'h5555_AAAA;
        return 32'h0;
    endfunction

    always @(posedge CLK) begin
        mdl_oe <= 1'b0;
        if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                if (!mdl_hang) begin
                    mdl_busy  <= 1'b0;
                    mdl_ready <= 1'b1;
                    if (!acc_we) begin
                        mdl_oe  <= 1'b1;
                        mdl_drv <= rd_word(acc_addr);
                    end
                end
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (sd_request && mdl_ready) begin
            mdl_busy  <= 1'b1;
            mdl_ready <= 1'b0;
            mdl_cnt   <= BUSY_CYC - 1;
            acc_we    <= sd_is_write;
            acc_addr  <= sd_address;
            if (sd_is_write) begin
                wr_addr <= sd_address;
                wr_data <= sd_data;
            end
        end else begin
            mdl_ready <= !mdl_off;
        end
    end

    assign sd_ready = mdl_ready;
    assign sd_data  = mdl_oe ? mdl_drv : (probe_oe ? PROBE : 32'bz);

    // ---------------- protocol monitor ----------------
    int multi_ack  = 0;
    int multi_done = 0;
    int stray_err  = 0;
    int ack_log[$];

    always @(negedge CLK) begin
        if (nRST) begin
            if ($countones(m_ack) > 1)  multi_ack++;
            if ($countones(m_done) > 1) multi_done++;
            if (m_err && m_done == '0)  stray_err++;
            for (int i = 0; i < NP; i++) begin
                if (m_ack[i]) ack_log.push_back(i);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe_z(input string tag);
        probe_oe = 1'b1;
        #1;
        check(tag, 64'(sd_data), 64'(PROBE));
        probe_oe = 1'b0;
    endtask

    task automatic wait_ack(input int limit);
        int cyc;
        cyc = 0;
        while (m_ack == '0 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (m_done == '0 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: run did not complete, expected $finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        logic [NP-1:0] done_acc;
        int          exp_order[6];
        int          got_gnt;

        exp_order = '{0, 1, 3, 0, 1, 3};
        nRST    = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;

        tick();
        tick();
        check("rst_ack",   64'(m_ack),       64'(0));
        check("rst_done",  64'(m_done),      64'(0));
        check("rst_err",   64'(m_err),       64'(0));
        check("rst_rdata", 64'(m_rdata),     64'(0));
        check("rst_sdreq", 64'(sd_request),  64'(0));
        check("rst_iswr",  64'(sd_is_write), 64'(0));
        check("rst_addr",  64'(sd_address),  64'(0));
        probe_z("rst_z");
        nRST = 1'b1;
        tick();

        // Single read from port 2.
        m_addr[64 +: 32] = 32'h0000_0100;
        m_req = 4'b0100;
        tick();
        check("rd_ack",   64'(m_ack),       64'(4'b0100));
        check("rd_sdreq", 64'(sd_request),  64'(1));
        check("rd_addr",  64'(sd_address),  64'(32'h100));
        check("rd_iswr",  64'(sd_is_write), 64'(0));
        probe_z("rd_issue_z");
        m_req = '0;
        tick();
        check("rd_ack_pulse", 64'(m_ack),      64'(0));
        check("rd_sdreq_off", 64'(sd_request), 64'(0));
        wait_done(40, cyc);
        check("rd_done",  64'(m_done),  64'(4'b0100));
        check("rd_err",   64'(m_err),   64'(0));
        check("rd_rdata", 64'(m_rdata), 64'(32'hCAFE_F00D));
        tick();
        check("rd_done_pulse", 64'(m_done), 64'(0));

        // Single write from port 0.
        m_we = 4'b0001;
        m_addr[0 +: 32]  = 32'h0000_0040;
        m_wdata[0 +: 32] = 32'h1234_5678;
        m_req = 4'b0001;
        tick();
        check("wr_ack",  64'(m_ack),       64'(4'b0001));
        check("wr_iswr", 64'(sd_is_write), 64'(1));
        check("wr_data", 64'(sd_data),     64'(32'h1234_5678));
        m_req = '0;
        tick();
        probe_z("wr_busy_z");
        wait_done(40, cyc);
        check("wr_done",      64'(m_done),  64'(4'b0001));
        check("wr_err",       64'(m_err),   64'(0));
        check("wr_rdata_keep", 64'(m_rdata), 64'(32'hCAFE_F00D));
        check("wr_mem_addr",  64'(wr_addr), 64'(32'h40));
        check("wr_mem_data",  64'(wr_data), 64'(32'h1234_5678));
        tick();
        probe_z("wr_after_z");

        // Controller not ready: nothing may be granted.
        m_we   = '0;
        m_addr = '0;
        mdl_off = 1'b1;
        tick();
        m_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_ack",   64'(m_ack),      64'(0));
            check("busy_sdreq", 64'(sd_request), 64'(0));
        end
        mdl_off = 1'b0;
        wait_ack(8);
        check("busy_resume_ack", 64'(m_ack), 64'(4'b0010));
        m_req = '0;
        wait_done(40, cyc);
        check("busy_done",  64'(m_done),  64'(4'b0010));
        check("busy_rdata", 64'(m_rdata), 64'(32'h5555_AAAA));
        tick();

        // Contention from reset: ports 0,1,3 held.
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ack_log.delete();
        m_req = 4'b1011;
        cyc = 0;
        while (ack_log.size() < 6 && cyc < 300) begin
            tick();
            cyc++;
        end
        m_req = '0;
        for (int i = 0; i < 6; i++) begin
            got_gnt = (i < ack_log.size()) ? ack_log[i] : -1;
            check($sformatf("rr_order[%0d]", i), 64'(got_gnt), 64'(exp_order[i]));
        end
        wait_done(40, cyc);
        check("rr_last_done", 64'(m_done), 64'(4'b1000));
        tick();

        // Timeout: controller accepts a write and never comes back.
        mdl_hang = 1'b1;
        m_we = 4'b0100;
        m_addr[64 +: 32] = 32'h0000_0080;
        m_req = 4'b0100;
        wait_ack(8);
        check("to_ack", 64'(m_ack), 64'(4'b0100));
        m_req = '0;
        wait_done(60, cyc);
        check("to_done",  64'(m_done),  64'(4'b0100));
        check("to_err",   64'(m_err),   64'(1));
        check("to_rdata", 64'(m_rdata), 64'(32'h5555_AAAA));
        check("to_latency_in_window", 64'(cyc >= 20 && cyc <= 23), 64'(1));
        tick();
        check("to_err_clear",  64'(m_err),  64'(0));
        check("to_done_clear", 64'(m_done), 64'(0));
        mdl_hang = 1'b0;
        m_we = '0;
        m_addr[0 +: 32] = 32'h0000_0100;
        m_req = 4'b0001;
        wait_ack(8);
        check("to_next_ack", 64'(m_ack), 64'(4'b0001));
        m_req = '0;
        wait_done(40, cyc);
        check("to_next_done",  64'(m_done),  64'(4'b0001));
        check("to_next_err",   64'(m_err),   64'(0));
        check("to_next_rdata", 64'(m_rdata), 64'(32'hCAFE_F00D));
        tick();

        // Reset during WAIT_DONE.
        m_addr[32 +: 32] = 32'h0000_0100;
        m_req = 4'b0010;
        wait_ack(8);
        check("rw_ack", 64'(m_ack), 64'(4'b0010));
        m_req = '0;
        tick();
        tick();
        tick();
        tick();
        #2;
        nRST = 1'b0;
        #1;
        check("rw_ack0",   64'(m_ack),       64'(0));
        check("rw_done0",  64'(m_done),      64'(0));
        check("rw_err0",   64'(m_err),       64'(0));
        check("rw_rdata0", 64'(m_rdata),     64'(0));
        check("rw_sdreq0", 64'(sd_request),  64'(0));
        check("rw_iswr0",  64'(sd_is_write), 64'(0));
        check("rw_addr0",  64'(sd_address),  64'(0));
        probe_z("rw_z");
        done_acc = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_acc = done_acc | m_done;
        end
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_acc = done_acc | m_done;
        end
        check("rw_no_done", 64'(done_acc), 64'(0));
        m_req = 4'b1111;
        wait_ack(8);
        check("rw_first_gnt", 64'(m_ack), 64'(4'b0001));
        m_req = '0;
        wait_done(40, cyc);
        check("rw_first_done", 64'(m_done), 64'(4'b0001));
        tick();

        check("mon_multi_ack",  64'(multi_ack),  64'(0));
        check("mon_multi_done", 64'(multi_done), 64'(0));
        check("mon_stray_err",  64'(stray_err),  64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
